// File: rtl/tennis_score_ctrl.sv
// Tennis point/game sequencer: edge-detected point buttons drive per-player
// thermometer score codes, deuce/advantage handling, game counting and set end.
module tennis_score_ctrl #(
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int GAMES_TO_WIN = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       point_a,
    input  logic       point_b,
    input  logic       clear,
    output logic [3:0] score_a,
    output logic [3:0] score_b,
    output logic [3:0] games_a,
    output logic [3:0] games_b,
    output logic       game_hold,
    output logic       winner_b,
    output logic       deuce,
    output logic       set_over,
    output logic       conflict
);

    localparam int               CNT_W     = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       GAMES_MAX = 4'(GAMES_TO_WIN);

    typedef enum logic [1:0] {PLAY, HOLD, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       lvl_a, lvl_b, lvl_a_nx, lvl_b_nx;
    logic [3:0]       gcnt_a, gcnt_b, gcnt_a_nx, gcnt_b_nx;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
    logic             win_b, win_b_nx;
    logic             conf, conf_nx;
    logic             pa_q, pb_q;
    logic             rise_a, rise_b;
    logic             a_wins, b_wins;

    function automatic logic [3:0] therm(input logic [2:0] lvl);
        case (lvl)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    assign rise_a = point_a & ~pa_q;
    assign rise_b = point_b & ~pb_q;

    // State register; edge-detect flops load 1 on reset so a held button never scores
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state    <= PLAY;
            lvl_a    <= 3'd0;
            lvl_b    <= 3'd0;
            gcnt_a   <= 4'd0;
            gcnt_b   <= 4'd0;
            hold_cnt <= '0;
            win_b    <= 1'b0;
            conf     <= 1'b0;
            pa_q     <= 1'b1;
            pb_q     <= 1'b1;
        end else begin
            state    <= state_nx;
            lvl_a    <= lvl_a_nx;
            lvl_b    <= lvl_b_nx;
            gcnt_a   <= gcnt_a_nx;
            gcnt_b   <= gcnt_b_nx;
            hold_cnt <= hold_cnt_nx;
            win_b    <= win_b_nx;
            conf     <= conf_nx;
            pa_q     <= point_a;
            pb_q     <= point_b;
        end
    end

    always_comb begin
        state_nx    = state;
        lvl_a_nx    = lvl_a;
        lvl_b_nx    = lvl_b;
        gcnt_a_nx   = gcnt_a;
        gcnt_b_nx   = gcnt_b;
        hold_cnt_nx = hold_cnt;
        win_b_nx    = win_b;
        conf_nx     = 1'b0;
        a_wins      = 1'b0;
        b_wins      = 1'b0;
        case (state)
            PLAY: begin
                if (rise_a && rise_b) begin
                    conf_nx = 1'b1;
                end else if (rise_a) begin
                    if (lvl_a == 3'd4 || (lvl_a == 3'd3 && lvl_b < 3'd3)) a_wins = 1'b1;
                    else if (lvl_a < 3'd3)                                lvl_a_nx = lvl_a + 3'd1;
                    else if (lvl_b == 3'd3)                               lvl_a_nx = 3'd4;
                    else                                                  lvl_b_nx = 3'd3;
                end else if (rise_b) begin
                    if (lvl_b == 3'd4 || (lvl_b == 3'd3 && lvl_a < 3'd3)) b_wins = 1'b1;
                    else if (lvl_b < 3'd3)                                lvl_b_nx = lvl_b + 3'd1;
                    else if (lvl_a == 3'd3)                               lvl_b_nx = 3'd4;
                    else                                                  lvl_a_nx = 3'd3;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx    = PLAY;
                    lvl_a_nx    = 3'd0;
                    lvl_b_nx    = 3'd0;
                    hold_cnt_nx = '0;
                end else begin
                    hold_cnt_nx = hold_cnt + 1'b1;
                end
            end
            DONE:    ;
            default: state_nx = PLAY;
        endcase

        // Winner displays 1111; the loser keeps its last level on display
        if (a_wins) begin
            lvl_a_nx    = 3'd4;
            gcnt_a_nx   = gcnt_a + 4'd1;
            win_b_nx    = 1'b0;
            hold_cnt_nx = '0;
            state_nx    = (gcnt_a + 4'd1 == GAMES_MAX) ? DONE : HOLD;
        end
        if (b_wins) begin
            lvl_b_nx    = 3'd4;
            gcnt_b_nx   = gcnt_b + 4'd1;
            win_b_nx    = 1'b1;
            hold_cnt_nx = '0;
            state_nx    = (gcnt_b + 4'd1 == GAMES_MAX) ? DONE : HOLD;
        end
    end

    always_comb begin
        score_a   = therm(lvl_a);
        score_b   = therm(lvl_b);
        games_a   = gcnt_a;
        games_b   = gcnt_b;
        game_hold = (state == HOLD);
        set_over  = (state == DONE);
        deuce     = (lvl_a == 3'd3) && (lvl_b == 3'd3);
        winner_b  = win_b;
        conflict  = conf;
    end

endmodule
